trap_vector_ctrl: RTL and testbench
===================================

// Module: trap_vector_ctrl
// PURPOSE
// Parametrised trap/interrupt controller replacing the combinational vector-address lookup. Latches NMI,
// ECALL, EBREAK, timer and NUM_IRQ external sources, arbitrates by fixed priority and holds a
// registered trap request with vector address, cause and EPC until the core acknowledges it. Tracks
// handler state until mret. Sits between the decode/exception logic and the PC-select mux.
// PARAMETERS
// XLEN         32       address/PC width
// NUM_IRQ      8        external interrupt lines, 1..128
// BASE_RST     32'h0    vector base after reset; bits [1:0] always forced 0
// IRQ_STRIDE   32'h10   byte spacing between external IRQ vectors
// PORTS
// clk             in   1        clock, rising edge
// rst_n           in   1        asynchronous reset, active low
// pc_in           in   XLEN     PC of the instruction at the trap point, captured as EPC
// exc_ecall       in   1        one-cycle pulse: ECALL retired
// exc_ebreak      in   1        one-cycle pulse: EBREAK retired
// nmi             in   1        non-maskable interrupt, rising-edge sensitive
// tmr_irq         in   1        timer interrupt, level sensitive, gated by tmr_en
// irq             in   NUM_IRQ  external interrupts, rising-edge sensitive
// gie_set         in   1        pulse: set global interrupt enable
// tmr_en          in   1        timer interrupt enable
// mask_we/mask_wd in   1/NUM_IRQ write IRQ enable mask (1 = enabled)
// base_we/base_wd in   1/XLEN   write vector base
// vec_mode        in   1        1 = vectored, 0 = direct (every trap to base)
// trap_ack        in   1        core accepts the request (PC redirected)
// mret            in   1        pulse: return from handler
// trap_req        out  1        request valid
// trap_addr       out  XLEN     handler address, stable while trap_req
// trap_cause      out  8        cause code, stable while trap_req
// epc             out  XLEN     saved PC, valid from request until next request
// in_handler      out  1        high in ACTIVE
// exc_err         out  1        one-cycle pulse: ECALL/EBREAK dropped
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; gie=0, mask=0, base=BASE_RST, all pending bits 0.
// - Pending: nmi_p set on nmi rising edge; irq_p[i] set on irq[i] rising edge (edge-detect regs). Latch
//   ignores mask/gie; pending cleared only when that source's trap is acknowledged.
// - Eligible: nmi_p always; ecall/ebreak pulses (not latched); tmr_irq&tmr_en&gie; irq_p[i]&mask[i]&gie.
// - Priority: NMI > EBREAK > ECALL > TMR > IRQ lowest index.
// - Cause: NMI=1, ECALL=2, EBREAK=3, TMR=4, IRQ i = 8'h80|i.
// - Address: vectored: NMI base+10h, ECALL base+20h, EBREAK base+30h, TMR base+40h,
//   IRQ base+100h+i*IRQ_STRIDE; all sums modulo 2^XLEN. Direct: base for every cause.
// - FSM IDLE: any eligible source in cycle N -> REQ; trap_req, trap_addr, trap_cause, epc registered,
//   visible at N+1 (1-cycle latency). gie cleared on entry, previous gie saved in pgie.
// - REQ: outputs frozen until trap_ack; ack in cycle M -> ACTIVE at M+1, winner's pending bit cleared at
//   M+1. trap_req low at M+1. New edges in REQ latch as pending; never change current outputs.
// - ACTIVE: in_handler=1; no new trap taken (NMI stays pending, no nesting). mret -> IDLE next cycle,
//   gie<=pgie. mret outside ACTIVE ignored.
// - exc_ecall/exc_ebreak in REQ or ACTIVE: dropped, exc_err pulses next cycle.
// - Simultaneous events: mask/base/gie writes take effect next cycle; selection uses old values.
//   base_we during REQ does not alter held trap_addr. gie_set and mret in same cycle: gie=1.
// - Reset asserted mid-request or mid-handler: immediate return to reset state, pending lost.
// STRUCTURE
// - Shared package/defines: cause codes, fixed vector offsets (10h/20h/30h/40h/100h), FSM state enum.
// - Sub-module: irq_prio_enc (NUM_IRQ-wide lowest-index-first encoder, outputs valid + index).
// - Rest flat: edge detectors, pending regs, FSM, address adder, output registers.
// TESTING
// - Reset; irq[2] rise, mask=04h, gie=1, base=0, vectored -> next cycle trap_req=1, addr=120h,
//   cause=82h; ack -> in_handler=1, irq_p[2]=0; mret -> IDLE, gie=1.
// - nmi rise with irq[0] pending and gie=0 -> addr=10h, cause=01h; irq[0] taken after mret only if gie=1.
// - ecall and tmr_irq (tmr_en=1, gie=1) same cycle, base=8000_0000h -> addr=8000_0020h, cause=02h,
//   epc=pc_in of that cycle.
// - vec_mode=0, base=4000h, irq[7] -> addr=4000h, cause=87h; base_we=5000h during REQ -> addr stays 4000h.
// - Base=FFFF_FF00h, NUM_IRQ=8, irq[7] -> addr=0000_0070h (wrap); ebreak in ACTIVE -> exc_err 1 cycle,
//   no request.
// - rst_n low while REQ -> trap_req=0 and all pending cleared asynchronously; no trap after release.

Source files
------------

// File: rtl/trap_vector_ctrl_pkg.sv
// Shared definitions for the trap/interrupt vector controller: FSM states,
// trap source tags, cause codes and the fixed vector offsets.
package trap_vector_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2
    } trap_state_e;

    typedef enum logic [2:0] {
        SRC_NONE   = 3'd0,
        SRC_NMI    = 3'd1,
        SRC_EBREAK = 3'd2,
        SRC_ECALL  = 3'd3,
        SRC_TMR    = 3'd4,
        SRC_IRQ    = 3'd5
    } trap_src_e;

    localparam logic [7:0] CAUSE_NMI      = 8'h01;
    localparam logic [7:0] CAUSE_ECALL    = 8'h02;
    localparam logic [7:0] CAUSE_EBREAK   = 8'h03;
    localparam logic [7:0] CAUSE_TMR      = 8'h04;
    localparam logic [7:0] CAUSE_IRQ_BASE = 8'h80;

    localparam logic [11:0] VEC_OFF_NMI    = 12'h010;
    localparam logic [11:0] VEC_OFF_ECALL  = 12'h020;
    localparam logic [11:0] VEC_OFF_EBREAK = 12'h030;
    localparam logic [11:0] VEC_OFF_TMR    = 12'h040;
    localparam logic [11:0] VEC_OFF_IRQ    = 12'h100;

endpackage

// File: rtl/trap_vector_ctrl_irq_prio_enc.sv
// Lowest-index-first priority encoder over the eligible external IRQ lines.
module irq_prio_enc #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/trap_vector_ctrl.sv
// Trap/interrupt controller: latches NMI and external IRQ edges, arbitrates
// NMI > EBREAK > ECALL > TMR > IRQ(lowest index), and holds a registered trap
// request (address, cause, EPC) until the core acknowledges it. Tracks the
// handler until mret.
//
// Handshake: trap_req is a valid that, once raised, holds trap_addr and
// trap_cause frozen until the cycle trap_ack is sampled high with trap_req
// high; trap_ack while trap_req is low has no effect.
module trap_vector_ctrl
    import trap_vector_ctrl_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              NUM_IRQ    = 8,
    parameter logic [XLEN-1:0] BASE_RST   = '0,
    parameter logic [XLEN-1:0] IRQ_STRIDE = XLEN'(32'h10)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [XLEN-1:0]    pc_in,
    input  logic               exc_ecall,
    input  logic               exc_ebreak,
    input  logic               nmi,
    input  logic               tmr_irq,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               gie_set,
    input  logic               tmr_en,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wd,
    input  logic               base_we,
    input  logic [XLEN-1:0]    base_wd,
    input  logic               vec_mode,
    input  logic               trap_ack,
    input  logic               mret,
    output logic               trap_req,
    output logic [XLEN-1:0]    trap_addr,
    output logic [7:0]         trap_cause,
    output logic [XLEN-1:0]    epc,
    output logic               in_handler,
    output logic               exc_err,
    output logic [1:0]         dbg_state
);

    localparam int              IW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [XLEN-1:0] BASE_MASK = ~XLEN'(3);

    trap_state_e        r_state;
    logic               r_nmi_d;
    logic [NUM_IRQ-1:0] r_irq_d;
    logic               r_nmi_p;
    logic [NUM_IRQ-1:0] r_irq_p;
    logic               r_gie;
    logic               r_pgie;
    logic [NUM_IRQ-1:0] r_mask;
    logic [XLEN-1:0]    r_base;
    trap_src_e          r_win_src;
    logic [IW-1:0]      r_win_idx;
    logic               r_trap_req;
    logic [XLEN-1:0]    r_trap_addr;
    logic [7:0]         r_trap_cause;
    logic [XLEN-1:0]    r_epc;
    logic               r_in_handler;
    logic               r_exc_err;

    logic               w_nmi_edge;
    logic [NUM_IRQ-1:0] w_irq_edge;
    logic               w_nmi_elig;
    logic               w_tmr_elig;
    logic [NUM_IRQ-1:0] w_irq_elig;
    logic               w_irq_valid;
    logic [IW-1:0]      w_irq_idx;
    logic               w_any;
    trap_src_e          w_src;
    logic [7:0]         w_cause;
    logic [XLEN-1:0]    w_off;
    logic [XLEN-1:0]    w_addr;
    logic               w_ack;
    logic               w_clr_nmi;
    logic [NUM_IRQ-1:0] w_clr_irq;

    // An edge arriving this cycle is already eligible, giving one-cycle latency.
    assign w_nmi_edge = nmi & ~r_nmi_d;
    assign w_irq_edge = irq & ~r_irq_d;
    assign w_nmi_elig = r_nmi_p | w_nmi_edge;
    assign w_tmr_elig = tmr_irq & tmr_en & r_gie;
    assign w_irq_elig = (r_irq_p | w_irq_edge) & r_mask & {NUM_IRQ{r_gie}};

    irq_prio_enc #(
        .N  (NUM_IRQ),
        .IW (IW)
    ) u_irq_prio_enc (
        .i_req   (w_irq_elig),
        .o_valid (w_irq_valid),
        .o_idx   (w_irq_idx)
    );

    // Fixed-priority winner selection with its cause code and vector offset.
    always_comb begin
        w_any   = 1'b0;
        w_src   = SRC_NONE;
        w_cause = '0;
        w_off   = '0;
        if (w_nmi_elig) begin
            w_any   = 1'b1;
            w_src   = SRC_NMI;
            w_cause = CAUSE_NMI;
            w_off   = XLEN'(VEC_OFF_NMI);
        end else if (exc_ebreak) begin
            w_any   = 1'b1;
            w_src   = SRC_EBREAK;
            w_cause = CAUSE_EBREAK;
            w_off   = XLEN'(VEC_OFF_EBREAK);
        end else if (exc_ecall) begin
            w_any   = 1'b1;
            w_src   = SRC_ECALL;
            w_cause = CAUSE_ECALL;
            w_off   = XLEN'(VEC_OFF_ECALL);
        end else if (w_tmr_elig) begin
            w_any   = 1'b1;
            w_src   = SRC_TMR;
            w_cause = CAUSE_TMR;
            w_off   = XLEN'(VEC_OFF_TMR);
        end else if (w_irq_valid) begin
            w_any   = 1'b1;
            w_src   = SRC_IRQ;
            w_cause = CAUSE_IRQ_BASE | 8'(w_irq_idx);
            w_off   = XLEN'(VEC_OFF_IRQ) + XLEN'(w_irq_idx) * IRQ_STRIDE;
        end
    end

    // Sums wrap modulo 2^XLEN; direct mode sends every trap to the base.
    assign w_addr = vec_mode ? (r_base + w_off) : r_base;

    assign w_ack     = (r_state == ST_REQ) & trap_ack;
    assign w_clr_nmi = w_ack & (r_win_src == SRC_NMI);
    assign w_clr_irq = (w_ack && (r_win_src == SRC_IRQ)) ? (NUM_IRQ'(1) << r_win_idx) : '0;

    // Edge detectors and pending latches; an edge in the ack cycle survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nmi_d <= 1'b0;
            r_irq_d <= '0;
            r_nmi_p <= 1'b0;
            r_irq_p <= '0;
        end else begin
            r_nmi_d <= nmi;
            r_irq_d <= irq;
            r_nmi_p <= (r_nmi_p & ~w_clr_nmi) | w_nmi_edge;
            r_irq_p <= (r_irq_p & ~w_clr_irq) | w_irq_edge;
        end
    end

    // Software-visible configuration: mask and vector base (word aligned).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '0;
            r_base <= BASE_RST & BASE_MASK;
        end else begin
            if (mask_we) r_mask <= mask_wd;
            if (base_we) r_base <= base_wd & BASE_MASK;
        end
    end

    // Trap FSM with registered request outputs and global interrupt enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_trap_req   <= 1'b0;
            r_trap_addr  <= '0;
            r_trap_cause <= '0;
            r_epc        <= '0;
            r_in_handler <= 1'b0;
            r_exc_err    <= 1'b0;
            r_gie        <= 1'b0;
            r_pgie       <= 1'b0;
            r_win_src    <= SRC_NONE;
            r_win_idx    <= '0;
        end else begin
            r_exc_err <= (exc_ecall | exc_ebreak) & (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state      <= ST_REQ;
                        r_trap_req   <= 1'b1;
                        r_trap_addr  <= w_addr;
                        r_trap_cause <= w_cause;
                        r_epc        <= pc_in;
                        r_win_src    <= w_src;
                        r_win_idx    <= w_irq_idx;
                        r_pgie       <= r_gie;
                        r_gie        <= 1'b0;
                    end else if (gie_set) begin
                        r_gie <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (trap_ack) begin
                        r_state      <= ST_ACTIVE;
                        r_trap_req   <= 1'b0;
                        r_in_handler <= 1'b1;
                    end
                    if (gie_set) r_gie <= 1'b1;
                end
                ST_ACTIVE: begin
                    if (mret) begin
                        r_state      <= ST_IDLE;
                        r_in_handler <= 1'b0;
                        r_gie        <= r_pgie | gie_set;
                    end else if (gie_set) begin
                        r_gie <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_trap_req   <= 1'b0;
                    r_in_handler <= 1'b0;
                end
            endcase
        end
    end

    assign trap_req   = r_trap_req;
    assign trap_addr  = r_trap_addr;
    assign trap_cause = r_trap_cause;
    assign epc        = r_epc;
    assign in_handler = r_in_handler;
    assign exc_err    = r_exc_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_trap_vector_ctrl.sv
// Bench for trap_vector_ctrl: directed scenarios plus randomized traffic,
// checked cycle by cycle against a behavioural model of the trap rules.
module tb_trap_vector_ctrl;

    localparam int          XLEN     = 32;
    localparam int          NIRQ     = 8;
    localparam logic [31:0] BASE_RST = 32'h0;
    localparam logic [31:0] STRIDE   = 32'h10;

    logic            clk;
    logic            rst_n;
    logic [31:0]     pc_in;
    logic            exc_ecall, exc_ebreak, nmi, tmr_irq;
    logic [NIRQ-1:0] irq;
    logic            gie_set, tmr_en, mask_we;
    logic [NIRQ-1:0] mask_wd;
    logic            base_we;
    logic [31:0]     base_wd;
    logic            vec_mode, trap_ack, mret;
    logic            trap_req;
    logic [31:0]     trap_addr;
    logic [7:0]      trap_cause;
    logic [31:0]     epc;
    logic            in_handler, exc_err;
    logic [1:0]      dbg_state;

    trap_vector_ctrl #(
        .XLEN       (XLEN),
        .NUM_IRQ    (NIRQ),
        .BASE_RST   (BASE_RST),
        .IRQ_STRIDE (STRIDE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_in      (pc_in),
        .exc_ecall  (exc_ecall),
        .exc_ebreak (exc_ebreak),
        .nmi        (nmi),
        .tmr_irq    (tmr_irq),
        .irq        (irq),
        .gie_set    (gie_set),
        .tmr_en     (tmr_en),
        .mask_we    (mask_we),
        .mask_wd    (mask_wd),
        .base_we    (base_we),
        .base_wd    (base_wd),
        .vec_mode   (vec_mode),
        .trap_ack   (trap_ack),
        .mret       (mret),
        .trap_req   (trap_req),
        .trap_addr  (trap_addr),
        .trap_cause (trap_cause),
        .epc        (epc),
        .in_handler (in_handler),
        .exc_err    (exc_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int         n_checks;
    int         n_fail;
    logic [7:0] exp_q[$];
    logic       dut_req_prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              m_phase;      // 0 waiting for trap, 1 request held, 2 in handler
    logic            m_gie, m_pgie;
    logic [NIRQ-1:0] m_mask;
    logic [31:0]     m_base;
    logic            m_nmi_p;
    logic [NIRQ-1:0] m_irq_p;
    logic            m_nmi_prev;
    logic [NIRQ-1:0] m_irq_prev;
    logic            m_win_nmi;
    int              m_win_irq;
    logic            e_req, e_inh, e_err;
    logic [31:0]     e_addr, e_epc;
    logic [7:0]      e_cause;

    task automatic model_reset();
        m_phase = 0; m_gie = 0; m_pgie = 0; m_mask = '0; m_base = BASE_RST & ~32'h3;
        m_nmi_p = 0; m_irq_p = '0; m_nmi_prev = 0; m_irq_prev = '0;
        m_win_nmi = 0; m_win_irq = -1;
        e_req = 0; e_inh = 0; e_err = 0; e_addr = '0; e_epc = '0; e_cause = '0;
        exp_q.delete();
        dut_req_prev = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_eval();
        logic            nmi_edge;
        logic [NIRQ-1:0] irq_edge;
        logic            found;
        logic [7:0]      cause;
        logic [31:0]     off;
        int              win_irq;
        nmi_edge = nmi & ~m_nmi_prev;
        irq_edge = irq & ~m_irq_prev;
        e_err = (exc_ecall | exc_ebreak) && (m_phase != 0);
        if (m_phase == 0) begin
            found = 1'b1; win_irq = -1; cause = 8'h00;
            if (m_nmi_p | nmi_edge)              cause = 8'h01;
            else if (exc_ebreak)                 cause = 8'h03;
            else if (exc_ecall)                  cause = 8'h02;
            else if (tmr_irq && tmr_en && m_gie) cause = 8'h04;
            else begin
                found = 1'b0;
                if (m_gie) begin
                    for (int i = 0; i < NIRQ; i++) begin
                        if (!found && (m_irq_p[i] | irq_edge[i]) && m_mask[i]) begin
                            found = 1'b1; win_irq = i; cause = 8'h80 | 8'(i);
                        end
                    end
                end
            end
            if (found) begin
                off = (win_irq >= 0) ? 32'h100 + 32'(win_irq) * STRIDE : 32'(cause) * 32'h10;
                e_addr  = vec_mode ? m_base + off : m_base;
                e_cause = cause;
                e_epc   = pc_in;
                e_req   = 1'b1;
                m_phase = 1;
                m_pgie  = m_gie;
                m_gie   = 1'b0;
                m_win_nmi = (cause == 8'h01);
                m_win_irq = win_irq;
                exp_q.push_back(cause);
            end else if (gie_set) begin
                m_gie = 1'b1;
            end
        end else if (m_phase == 1) begin
            if (trap_ack) begin
                m_phase = 2; e_req = 1'b0; e_inh = 1'b1;
                if (m_win_nmi) m_nmi_p = 1'b0;
                if (m_win_irq >= 0) m_irq_p[m_win_irq] = 1'b0;
            end
            if (gie_set) m_gie = 1'b1;
        end else begin
            if (mret) begin
                m_phase = 0; e_inh = 1'b0; m_gie = m_pgie | gie_set;
            end else if (gie_set) begin
                m_gie = 1'b1;
            end
        end
        m_nmi_p = m_nmi_p | nmi_edge;
        m_irq_p = m_irq_p | irq_edge;
        if (mask_we) m_mask = mask_wd;
        if (base_we) m_base = base_wd & ~32'h3;
        m_nmi_prev = nmi;
        m_irq_prev = irq;
    endtask

    task automatic compare_all();
        logic [7:0] want;
        chk("trap_req", 32'(trap_req), 32'(e_req));
        if (e_req) begin
            chk("trap_addr", trap_addr, e_addr);
            chk("trap_cause", 32'(trap_cause), 32'(e_cause));
        end
        chk("epc", epc, e_epc);
        chk("in_handler", 32'(in_handler), 32'(e_inh));
        chk("exc_err", 32'(exc_err), 32'(e_err));
        if (trap_req && !dut_req_prev) begin
            if (exp_q.size() > 0) want = exp_q.pop_front();
            else                  want = 8'h00;
            chk("trap_order", 32'(trap_cause), 32'(want));
        end
        dut_req_prev = trap_req;
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        pc_in = '0; exc_ecall = 0; exc_ebreak = 0; nmi = 0; tmr_irq = 0; irq = '0;
        gie_set = 0; tmr_en = 0; mask_we = 0; mask_wd = '0; base_we = 0; base_wd = '0;
        vec_mode = 0; trap_ack = 0; mret = 0;
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic cycle();
        model_eval();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        exc_ecall = 0; exc_ebreak = 0; gie_set = 0; mask_we = 0; base_we = 0;
        trap_ack = 0; mret = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        do_reset();
        #1;
        chk("rst_trap_req", 32'(trap_req), 32'h0);
        chk("rst_addr", trap_addr, 32'h0);
        chk("rst_cause", 32'(trap_cause), 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_in_handler", 32'(in_handler), 32'h0);
        chk("rst_exc_err", 32'(exc_err), 32'h0);
        @(negedge clk);

        // IRQ2 vectored, ack, mret restores gie
        mask_we = 1; mask_wd = 8'h04; gie_set = 1; vec_mode = 1; base_we = 1; base_wd = 32'h0;
        cycle();
        irq = 8'h04; pc_in = 32'h0000_0A00;
        cycle();
        chk("t1_req", 32'(trap_req), 32'h1);
        chk("t1_addr", trap_addr, 32'h120);
        chk("t1_cause", 32'(trap_cause), 32'h82);
        trap_ack = 1; cycle();
        chk("t1_in_handler", 32'(in_handler), 32'h1);
        mret = 1; cycle();
        chk("t1_mret", 32'(in_handler), 32'h0);
        cycle();
        chk("t1_pending_cleared", 32'(trap_req), 32'h0);
        irq = 8'h00; cycle();
        irq = 8'h04; cycle();
        chk("t1_gie_restored", 32'(trap_req), 32'h1);
        trap_ack = 1; cycle();
        mret = 1; cycle();

        // NMI beats pending IRQ0 with gie=0; IRQ0 waits for gie
        do_reset();
        mask_we = 1; mask_wd = 8'h01; vec_mode = 1; cycle();
        irq = 8'h01; cycle();
        chk("t2_irq0_blocked", 32'(trap_req), 32'h0);
        nmi = 1; cycle();
        chk("t2_nmi_addr", trap_addr, 32'h10);
        chk("t2_nmi_cause", 32'(trap_cause), 32'h01);
        trap_ack = 1; cycle();
        mret = 1; cycle();
        cycle(); cycle();
        chk("t2_irq0_held", 32'(trap_req), 32'h0);
        gie_set = 1; cycle();
        cycle();
        chk("t2_irq0_taken", 32'(trap_cause), 32'h80);
        chk("t2_irq0_addr", trap_addr, 32'h100);
        trap_ack = 1; nmi = 0; irq = 8'h00; cycle();
        mret = 1; cycle();

        // ECALL beats timer
        base_we = 1; base_wd = 32'h8000_0000; tmr_en = 1; cycle();
        exc_ecall = 1; tmr_irq = 1; pc_in = 32'h1234_5678; cycle();
        chk("t3_addr", trap_addr, 32'h8000_0020);
        chk("t3_cause", 32'(trap_cause), 32'h02);
        chk("t3_epc", epc, 32'h1234_5678);
        trap_ack = 1; tmr_irq = 0; cycle();
        mret = 1; cycle();

        // Direct mode; base write during request does not move held address
        vec_mode = 0; base_we = 1; base_wd = 32'h4000; mask_we = 1; mask_wd = 8'h80; cycle();
        irq = 8'h80; cycle();
        chk("t4_addr", trap_addr, 32'h4000);
        chk("t4_cause", 32'(trap_cause), 32'h87);
        base_we = 1; base_wd = 32'h5000; cycle();
        chk("t4_addr_frozen", trap_addr, 32'h4000);
        trap_ack = 1; cycle();
        mret = 1; cycle();

        // Address wrap, then EBREAK dropped in handler
        vec_mode = 1; base_we = 1; base_wd = 32'hFFFF_FF00; irq = 8'h00; cycle();
        irq = 8'h80; cycle();
        chk("t5_wrap_addr", trap_addr, 32'h70);
        trap_ack = 1; cycle();
        exc_ebreak = 1; cycle();
        chk("t5_exc_err", 32'(exc_err), 32'h1);
        chk("t5_no_req", 32'(trap_req), 32'h0);
        cycle();
        chk("t5_exc_err_pulse", 32'(exc_err), 32'h0);
        mret = 1; cycle();

        // Reset while a request is held, with NMI also pending
        irq = 8'h00; cycle();
        irq = 8'h80; cycle();
        nmi = 1; cycle();
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async_req", 32'(trap_req), 32'h0);
        chk("t6_async_epc", epc, 32'h0);
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cycle();
        chk("t6_no_trap_after_reset", 32'(trap_req), 32'h0);

        // Randomized traffic
        vec_mode = 1;
        for (int n = 0; n < 800; n++) begin
            pc_in = $urandom;
            if ($urandom_range(0, 15) == 0) nmi = ~nmi;
            if ($urandom_range(0, 2) == 0) irq = irq ^ NIRQ'(1 << $urandom_range(0, NIRQ - 1));
            exc_ecall  = ($urandom_range(0, 9) == 0);
            exc_ebreak = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 9) == 0) tmr_irq = ~tmr_irq;
            if ($urandom_range(0, 19) == 0) tmr_en = ~tmr_en;
            gie_set = ($urandom_range(0, 7) == 0);
            mask_we = ($urandom_range(0, 19) == 0);
            mask_wd = NIRQ'($urandom);
            base_we = ($urandom_range(0, 29) == 0);
            base_wd = $urandom;
            if ($urandom_range(0, 29) == 0) vec_mode = ~vec_mode;
            trap_ack = ($urandom_range(0, 2) == 0);
            mret     = ($urandom_range(0, 3) == 0);
            cycle();
        end

        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
